rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Shares the register file's single write port between several writeback sources (ALU, LSU, CSR unit) using round-robin arbitration and a valid/ready handshake. It registers the winning write and drives the register file's `wen`/`waddr`/`wdata` one cycle later. An optional busy-bit scoreboard tracks destinations with writes still outstanding, so issue logic can stall on RAW hazards. The block sits between the execute/memory units and the register file.

## Interface

Parameters:
- `NUM_REQ`, default 3: number of writeback requesters.
- `ADDR_WIDTH`, default 5: register address width.
- `DATA_WIDTH`, default 32: register data width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in NUM_REQ: per-requester write request.
- `req_ready` out NUM_REQ: per-requester grant. A transfer occurs when `req_valid[i] & req_ready[i]`.
- `req_addr` in NUM_REQ*ADDR_WIDTH: packed destination addresses. Requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_data` in NUM_REQ*DATA_WIDTH: packed write data, sliced the same way.
- `rf_wen` out 1: register file write enable.
- `rf_waddr` out ADDR_WIDTH: register file write address.
- `rf_wdata` out DATA_WIDTH: register file write data.
- `issue_valid` in 1: an instruction with destination `issue_addr` has been issued (scoreboard set).
- `issue_addr` in ADDR_WIDTH: destination register of the issued instruction.
- `query_addr1`, `query_addr2` in ADDR_WIDTH: source registers to check.
- `query_busy1`, `query_busy2` out 1: the queried register has a pending write.

## Operation

- **Round-robin pointer.** `ptr` holds the index of the last granted requester.
  - Search order each cycle is ptr+1, ptr+2, … modulo NUM_REQ.
  - The first requester with `req_valid` high receives `req_ready`.
  - At most one bit of `req_ready` is high. All bits are 0 when no request is valid.
- **Grant timing.** `req_ready` is combinational from `req_valid` and `ptr`.
  - The write port never stalls, so a valid requester with priority is always granted in the same cycle.
  - Requesters must not make `req_valid` depend on `req_ready`.
- **Pointer update.** On a transfer, `ptr` ← granted index. With no transfer, `ptr` holds its value.
- **Output register.** On a transfer:
  - `rf_waddr` and `rf_wdata` ← the granted requester's slices.
  - `rf_wen` ← 1 if the address is nonzero, 0 if the address is zero.
  - A transfer to address 0 is still accepted and still advances `ptr`.
- **Idle.** With no transfer, `rf_wen` ← 0. `rf_waddr` and `rf_wdata` hold their previous values.
- **Request inputs.** Data and address are sampled only at the transfer edge.
- **Scoreboard** (when configured): one busy bit per register; entry 0 is never set.
  - Set: at the clock edge, if `issue_valid` and `issue_addr` ≠ 0, busy[issue_addr] ← 1.
  - Clear: at the clock edge, if `rf_wen`, busy[rf_waddr] ← 0.
  - Set and clear of the same address in the same cycle: set wins, because a newer producer has been issued.
  - `query_busyN` = busy[query_addrN], combinational.
  - No bypass: during the `rf_wen` cycle the bit still reads 1, since the data is not yet in the register file.

## Timing

- Latency is 1 cycle, from the transfer edge to `rf_wen` high with the matching address and data.
- Throughput is one write per cycle. Back-to-back grants are allowed, to the same or different requesters.
- Busy-bit latency: the bit reads 1 from the cycle after `issue_valid`. It reads 0 from the cycle after the `rf_wen` cycle.
- Reset values:
  - `rf_wen` = 0.
  - `rf_waddr` = 0.
  - `rf_wdata` = 0.
  - `ptr` = NUM_REQ-1, so requester 0 wins first.
  - All busy bits = 0.
- Reset in the middle of operation:
  - A registered write not yet presented is dropped.
  - The scoreboard is cleared.
  - `req_ready` is held at all-zero while `rst` is high.

## Configuration

- Macro: `RF_WB_SCOREBOARD_EN`.
- Defined: the scoreboard is built as described above.
- Undefined:
  - No busy storage is built.
  - `query_busy1` and `query_busy2` are tied to 0.
  - `issue_valid` and `issue_addr` are ignored.
  - The port list is unchanged.

## Structure

- Package `rf_pkg` holds:
  - the default ADDR_WIDTH, DATA_WIDTH and NUM_REQ;
  - requester index constants `WB_ALU`=0, `WB_LSU`=1, `WB_CSR`=2.
- One sub-module, `rr_arbiter`: a parameterised combinational round-robin grant.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `grant` and encoded `grant_idx`.
- The pointer register, output register and scoreboard stay in the top level.

## Test plan

1. **Reset.** Assert `rst` mid-cycle. Expect `rf_wen`=0, address and data 0, `req_ready`=0, and all busy bits 0.
2. **Rotation.** Hold all three `req_valid` high for 4 cycles after reset. Expect grant order 0,1,2,0. Each `rf_wen` follows its grant by one cycle with the matching addr/data (e.g. x5=0x11, x6=0x22, x7=0x33).
3. **Single requester.** Drive only requester 1 with x3=0xDEADBEEF. Expect an immediate grant and, next cycle, `rf_wen`=1, `rf_waddr`=3, `rf_wdata`=0xDEADBEEF.
4. **Zero address.** Drive requester 2 with address 0 and data 0xFFFF. Expect the handshake to complete and `ptr`=2, with `rf_wen` staying 0.
5. **Scoreboard.** Issue x9. Expect `query_busy1` for x9 to be 1 in the next cycle. Write x9 through requester 0 and expect busy to clear the cycle after `rf_wen`. Then issue x9 in the same cycle as its `rf_wen` and expect busy to stay 1.
6. **Macro off.** Build with `RF_WB_SCOREBOARD_EN` undefined and repeat scenario 5. Expect both query outputs to stay 0.

Source files
------------

// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared constants for the register-file writeback arbiter:
//   - default requester count, register address width and data width
//   - requester index constants (ALU, LSU, CSR unit)
//   - idx_width(): width of an index able to address n requesters
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int DEF_NUM_REQ    = 3;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;

    localparam int WB_ALU = 0;
    localparam int WB_LSU = 1;
    localparam int WB_CSR = 2;

    // A single requester still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant. The search starts one past the last
// granted index and wraps modulo NUM_REQ; the first active request wins.
// Ports:
//   req       in  NUM_REQ : request vector
//   ptr       in  IDX_W   : index of the last granted requester
//   grant     out NUM_REQ : one-hot grant, all zero when no request
//   grant_idx out IDX_W   : encoded grant (0 when no request)
// ---------------------------------------------------------------------------
module rr_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise a path that skips the assignment infers a latch.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((int'(ptr) + off) % NUM_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
// Shares the register file's single write port between NUM_REQ writeback
// sources with round-robin arbitration. The winning write is registered and
// presented on rf_wen/rf_waddr/rf_wdata one cycle after the transfer.
// Optional busy-bit scoreboard, built only when RF_WB_SCOREBOARD_EN is
// defined; otherwise query_busy1/2 are tied low and issue_* are ignored.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      per-requester handshake (NUM_REQ bits)
//   req_addr/req_data        packed per-requester address/data slices
//   rf_wen/rf_waddr/rf_wdata registered register-file write port
//   issue_valid/issue_addr   destination of a newly issued instruction
//   query_addr1/2            source registers to check
//   query_busy1/2            queried register has a pending write
// ---------------------------------------------------------------------------
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic                          rf_wen,
    output logic [ADDR_WIDTH-1:0]         rf_waddr,
    output logic [DATA_WIDTH-1:0]         rf_wdata,
    input  logic                          issue_valid,
    input  logic [ADDR_WIDTH-1:0]         issue_addr,
    input  logic [ADDR_WIDTH-1:0]         query_addr1,
    input  logic [ADDR_WIDTH-1:0]         query_addr2,
    output logic                          query_busy1,
    output logic                          query_busy2
);

    localparam int IDX_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      grant_idx;
    logic [IDX_W-1:0]      ptr;
    logic                  transfer;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // The write port never stalls, so a grant is always a transfer; reset
    // only has to mask the grant.
    assign req_ready = rst ? '0 : grant;
    assign transfer  = |(req_valid & req_ready);

    // One-hot mux of the granted requester's slices.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Reset value NUM_REQ-1 makes requester 0 the first winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            ptr <= IDX_W'(NUM_REQ - 1);
        end else if (transfer) begin
            ptr <= grant_idx;
        end
    end

    // Writes to x0 are accepted but never enabled at the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (transfer) begin
            rf_wen   <= (sel_addr != '0);
            rf_waddr <= sel_addr;
            rf_wdata <= sel_data;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

`ifdef RF_WB_SCOREBOARD_EN
    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [NUM_REGS-1:0] busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: busy bits are a flop vector, not RAM, so they are reset;
            // stale bits after reset would stall issue forever.
            busy <= '0;
        end else begin
            if (rf_wen) begin
                busy[rf_waddr] <= 1'b0;
            end
            // Placed after the clear so a same-cycle set for a newer
            // producer wins.
            if (issue_valid && (issue_addr != '0)) begin
                busy[issue_addr] <= 1'b1;
            end
        end
    end

    // No bypass: the bit stays set during the rf_wen cycle.
    assign query_busy1 = busy[query_addr1];
    assign query_busy2 = busy[query_addr2];
`else
    logic unused_issue;
    assign unused_issue = &{1'b0, issue_valid, issue_addr};

    assign query_busy1 = 1'b0;
    assign query_busy2 = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
// Self-checking bench for rf_wb_arbiter with a behavioural model of the
// round-robin grant, registered write port and busy-bit scoreboard.
// Scoreboard expectations follow RF_WB_SCOREBOARD_EN as seen by this file.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    localparam int NR = DEF_NUM_REQ;
    localparam int AW = DEF_ADDR_WIDTH;
    localparam int DW = DEF_DATA_WIDTH;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic             rf_wen;
    logic [AW-1:0]    rf_waddr;
    logic [DW-1:0]    rf_wdata;
    logic             issue_valid;
    logic [AW-1:0]    issue_addr;
    logic [AW-1:0]    query_addr1;
    logic [AW-1:0]    query_addr2;
    logic             query_busy1;
    logic             query_busy2;

    int n_checks = 0;
    int n_fail   = 0;

    rf_wb_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .query_addr1 (query_addr1),
        .query_addr2 (query_addr2),
        .query_busy1 (query_busy1),
        .query_busy2 (query_busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int            m_last;
    bit            m_wen;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    bit            m_busy [1<<AW];

    task automatic model_reset();
        m_last  = NR - 1;
        m_wen   = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        for (int i = 0; i < (1 << AW); i++) m_busy[i] = 1'b0;
    endtask

    // Round robin: first valid requester after the last winner, wrapping.
    function automatic int exp_winner(input logic [NR-1:0] v);
        for (int k = 1; k <= NR; k++) begin
            int idx = (m_last + k) % NR;
            if (((v >> idx) & NR'(1)) != '0) return idx;
        end
        return -1;
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a);
`ifdef RF_WB_SCOREBOARD_EN
        return m_busy[a];
`else
        return (a != a);
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check at negedge+1, update model at posedge.
    task automatic cycle(input logic [NR-1:0] v, input logic [NR*AW-1:0] a,
                         input logic [NR*DW-1:0] d, input logic iv,
                         input logic [AW-1:0] ia, input logic [AW-1:0] q1,
                         input logic [AW-1:0] q2);
        int            w;
        logic [NR-1:0] er;
        @(negedge clk);
        req_valid   = v;
        req_addr    = a;
        req_data    = d;
        issue_valid = iv;
        issue_addr  = ia;
        query_addr1 = q1;
        query_addr2 = q2;
        #1;
        w  = exp_winner(v);
        er = '0;
        if (w >= 0) er = NR'(1) << w;
        check("req_ready",   64'(req_ready),   64'(er));
        check("rf_wen",      64'(rf_wen),      64'(m_wen));
        check("rf_waddr",    64'(rf_waddr),    64'(m_waddr));
        check("rf_wdata",    64'(rf_wdata),    64'(m_wdata));
        check("query_busy1", 64'(query_busy1), 64'(exp_busy(q1)));
        check("query_busy2", 64'(query_busy2), 64'(exp_busy(q2)));
        @(posedge clk);
        if (m_wen) m_busy[m_waddr] = 1'b0;
        if (iv && ia != '0) m_busy[ia] = 1'b1;
        if (w >= 0) begin
            m_last  = w;
            m_waddr = a[w*AW +: AW];
            m_wdata = d[w*DW +: DW];
            m_wen   = (m_waddr != '0);
        end else begin
            m_wen = 1'b0;
        end
    endtask

    task automatic random_cycles(input int n);
        logic [NR*AW-1:0] a;
        logic [NR*DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            for (int r = 0; r < NR; r++) begin
                a[r*AW +: AW] = AW'($urandom_range(0, 7));
                d[r*DW +: DW] = DW'($urandom);
            end
            cycle(NR'($urandom_range(0, 7)), a, d, 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                  AW'($urandom_range(0, 7)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NR*AW-1:0] rot_a;
        logic [NR*DW-1:0] rot_d;
        logic [NR*AW-1:0] x9_a;
        logic [NR*DW-1:0] x9_d;
        rot_a = {5'd7, 5'd6, 5'd5};
        rot_d = {32'h33, 32'h22, 32'h11};
        x9_a  = {5'd0, 5'd0, 5'd9};
        x9_d  = {32'h0, 32'h0, 32'h99};

        // Reset state, with requests pending while rst is high.
        rst         = 1'b1;
        req_valid   = '1;
        req_addr    = rot_a;
        req_data    = rot_d;
        issue_valid = 1'b0;
        issue_addr  = '0;
        query_addr1 = 5'd5;
        query_addr2 = 5'd9;
        model_reset();
        #12;
        check("rst_req_ready", 64'(req_ready),   64'(0));
        check("rst_rf_wen",    64'(rf_wen),      64'(0));
        check("rst_rf_waddr",  64'(rf_waddr),    64'(0));
        check("rst_rf_wdata",  64'(rf_wdata),    64'(0));
        check("rst_busy1",     64'(query_busy1), 64'(0));
        check("rst_busy2",     64'(query_busy2), 64'(0));
        @(negedge clk);
        req_valid = '0;
        rst       = 1'b0;

        // Rotation: grant order 0,1,2,0.
        repeat (4) cycle(3'b111, rot_a, rot_d, 1'b0, 5'd0, 5'd0, 5'd0);
        cycle(3'b000, rot_a, rot_d, 1'b0, 5'd0, 5'd0, 5'd0);

        // Single requester (LSU) writing x3.
        cycle(NR'(1) << WB_LSU, {5'd0, 5'd3, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0},
              1'b0, 5'd0, 5'd0, 5'd0);
        // Zero address from the CSR requester: accepted, no write enable.
        cycle(NR'(1) << WB_CSR, {5'd0, 5'd0, 5'd0}, {32'hFFFF, 32'h0, 32'h0},
              1'b0, 5'd0, 5'd0, 5'd0);
        // ptr is now 2, so requester 0 must win next.
        cycle(3'b111, rot_a, rot_d, 1'b0, 5'd0, 5'd0, 5'd0);
        cycle(3'b000, rot_a, rot_d, 1'b0, 5'd0, 5'd0, 5'd0);

        // Scoreboard: issue x9, write it back, then set+clear collision.
        cycle(3'b000, x9_a, x9_d, 1'b1, 5'd9, 5'd9, 5'd3);
        cycle(3'b001, x9_a, x9_d, 1'b0, 5'd0, 5'd9, 5'd3);
        cycle(3'b000, x9_a, x9_d, 1'b0, 5'd0, 5'd9, 5'd9);
        cycle(3'b001, x9_a, x9_d, 1'b0, 5'd0, 5'd9, 5'd0);
        cycle(3'b000, x9_a, x9_d, 1'b1, 5'd9, 5'd9, 5'd9);
        cycle(3'b001, x9_a, x9_d, 1'b0, 5'd0, 5'd9, 5'd9);
        cycle(3'b000, x9_a, x9_d, 1'b0, 5'd0, 5'd9, 5'd9);
        cycle(3'b000, x9_a, x9_d, 1'b0, 5'd0, 5'd9, 5'd9);

        random_cycles(300);

        // Reset mid-operation with a registered write pending and x12 busy.
        cycle(3'b111, rot_a, rot_d, 1'b1, 5'd12, 5'd12, 5'd5);
        @(negedge clk);
        req_valid   = 3'b111;
        query_addr1 = 5'd12;
        query_addr2 = 5'd5;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("midrst_req_ready", 64'(req_ready),   64'(0));
        check("midrst_rf_wen",    64'(rf_wen),      64'(0));
        check("midrst_rf_waddr",  64'(rf_waddr),    64'(0));
        check("midrst_rf_wdata",  64'(rf_wdata),    64'(0));
        check("midrst_busy1",     64'(query_busy1), 64'(0));
        check("midrst_busy2",     64'(query_busy2), 64'(0));
        @(posedge clk);
        #1;
        check("midrst_hold_ready", 64'(req_ready), 64'(0));
        check("midrst_hold_wen",   64'(rf_wen),    64'(0));
        @(negedge clk);
        req_valid   = '0;
        issue_valid = 1'b0;
        rst         = 1'b0;

        // Requester 0 wins first again after reset.
        cycle(3'b111, rot_a, rot_d, 1'b0, 5'd0, 5'd12, 5'd5);
        random_cycles(50);
        cycle(3'b000, rot_a, rot_d, 1'b0, 5'd0, 5'd0, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
